ifetch_ctrl: RTL and testbench
==============================

Name: ifetch_ctrl

Overview:
Instruction-fetch front end that owns the fetch PC and issues 8-byte-aligned requests to instruction memory. It returns each 64-bit fetch group, tagged with its PC, to the instruction queue over the if_iq valid/ready interface. It accepts redirects from flush (highest priority) and from the queue's branch predictor, and discards stale in-flight responses. It is the transmitting end of the if_iq interface.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, fetch PC loaded at reset.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RSTn  in  1  asynchronous, active-low reset.
flush  in  1  pipeline flush redirect; has priority over branch_pc_valid.
flush_pc  in  64  redirect target when flush=1.
branch_pc_valid  in  1  predictor redirect from the instruction queue.
branch_pc  in  64  predictor target.
imem_req_valid  out  1  fetch request valid.
imem_req_addr  out  64  request address, bits [2:0] always 0.
imem_req_ready  in  1  memory accepts the request this cycle.
imem_rsp_valid  in  1  response data valid; exactly one response per accepted request, in order.
imem_rsp_data  in  64  fetch group.
if_iq_valid  out  1  fetch group valid to the queue.
if_iq_pc  out  64  PC of the first useful byte (may be 2/4/6 mod 8).
if_iq_instr  out  64  raw aligned 64-bit group.
if_iq_ready  in  1  queue accepts; may depend combinationally on if_iq_valid.

Behaviour:
- Reset is asynchronous (RSTn=0):
  - state=REQ, pc_q=RESET_PC, kill_q=0.
  - if_iq_valid=0, if_iq_pc=0, if_iq_instr=0.
  - imem_req_valid asserts in the first cycle after release.
- Redirect: redir = flush | branch_pc_valid; tgt = flush ? flush_pc : branch_pc. An unaligned tgt is kept verbatim in pc_q.
- imem_req_addr = {pc_q[63:3],3'b0} whenever imem_req_valid=1.
- State REQ: imem_req_valid=1, if_iq_valid=0.
  - req_ready & ~redir -> WAIT.
  - req_ready & redir -> pc_q<=tgt, kill_q<=1, WAIT. The accepted request is stale.
  - ~req_ready & redir -> pc_q<=tgt, stay in REQ. imem_req_addr may change while unaccepted; the memory must tolerate this.
- State WAIT: imem_req_valid=0, if_iq_valid=0.
  - redir (with or without rsp) -> pc_q<=tgt, kill_q<=1 (only if no rsp this cycle).
  - rsp & (kill_q | redir) -> drop data, kill_q<=0, go to REQ.
  - rsp & ~kill_q & ~redir -> out_instr<=rsp_data, out_pc<=pc_q, go to HOLD. Latency is 1 cycle from rsp to if_iq_valid.
- State HOLD: if_iq_valid=1; outputs are held stable until handshake or redirect.
  - Valid never waits on ready. Ready may be derived from valid; there is no combinational path from if_iq_ready to if_iq_valid.
  - redir -> pc_q<=tgt, if_iq_valid<=0, go to REQ. This applies even if if_iq_ready=1 in the same cycle: the transfer is void on this side and the queue discards it.
  - ready & ~redir -> pc_q<={pc_q[63:3],3'b0}+64'd8 (wraps modulo 2^64), go to REQ.
- Stale tracking: at most one request is outstanding, so kill_q is a single bit. A second redirect while kill_q=1 only updates pc_q.
- imem_rsp_valid outside WAIT is a protocol error. It is ignored and flagged by a simulation-only assertion.
- Throughput: one group per 3 cycles with single-cycle memory (REQ, WAIT, HOLD). Pipelining is out of scope.
- The output data registers are not cleared by redirect; only if_iq_valid qualifies them.

Test Plan:
1. Reset release with RSTn 0->1, mem ready and 1-cycle rsp, iq ready=1 -> req addrs 0x80000000, 0x80000008, 0x80000010; if_iq_pc matches each; if_iq_instr = rsp_data.
2. branch_pc_valid=1, branch_pc=0x80001006 while in HOLD -> if_iq_valid=0 next cycle; next req addr 0x80001000; if_iq_pc=0x80001006; following req 0x80001008.
3. flush=1 (flush_pc=0x100) and branch_pc_valid=1 (branch_pc=0x200) in the same WAIT cycle as rsp -> rsp dropped, no if_iq_valid; next req addr 0x100.
4. Redirect to 0x300 in WAIT one cycle before rsp -> that rsp dropped (kill_q consumed); next req addr 0x300 and its data delivered with if_iq_pc=0x300.
5. iq ready held 0 for 5 cycles in HOLD -> if_iq_valid/pc/instr stable; no imem_req_valid; ready=1 -> next req at pc+8.
6. RSTn pulsed low mid-WAIT -> outputs 0 immediately; after release req addr=RESET_PC; late rsp before the new request is accepted triggers the assertion and changes nothing.

Source files
------------

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch front end: owns the fetch PC, issues aligned 8-byte requests
// and hands each returned 64-bit group to the instruction queue.
module ifetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        flush,
  input  logic [63:0] flush_pc,
  input  logic        branch_pc_valid,
  input  logic [63:0] branch_pc,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [63:0] imem_rsp_data,
  output logic        if_iq_valid,
  output logic [63:0] if_iq_pc,
  output logic [63:0] if_iq_instr,
  input  logic        if_iq_ready
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [63:0] r_pc;
  logic [63:0] w_pc_nxt;
  logic        r_kill;
  logic        w_kill_nxt;
  logic [63:0] r_out_pc_p1;
  logic [63:0] r_out_instr_p1;
  logic        w_load;
  logic        w_redir;
  logic [63:0] w_tgt;
  logic [63:0] w_pc_aligned;

  assign w_redir      = flush | branch_pc_valid;
  assign w_tgt        = flush ? flush_pc : branch_pc;
  assign w_pc_aligned = {r_pc[63:3], 3'b000};

  assign imem_req_valid = (r_state == S_REQ);
  assign imem_req_addr  = w_pc_aligned;
  assign if_iq_valid    = (r_state == S_HOLD);
  assign if_iq_pc       = r_out_pc_p1;
  assign if_iq_instr    = r_out_instr_p1;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_kill_nxt  = r_kill;
    w_load      = 1'b0;
    case (r_state)
      S_REQ: begin
        if (w_redir) w_pc_nxt = w_tgt;
        if (imem_req_ready) begin
          // A redirect in the accepting cycle makes the accepted request stale.
          w_kill_nxt  = w_redir;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_redir) w_pc_nxt = w_tgt;
        if (imem_rsp_valid) begin
          w_kill_nxt = 1'b0;
          if (r_kill || w_redir) begin
            w_state_nxt = S_REQ;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end else if (w_redir) begin
          w_kill_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        // Redirect voids the transfer even when the queue is ready this cycle.
        if (w_redir) begin
          w_pc_nxt    = w_tgt;
          w_state_nxt = S_REQ;
        end else if (if_iq_ready) begin
          w_pc_nxt    = w_pc_aligned + 64'd8;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_kill  <= w_kill_nxt;
    end
  end

  // Response capture stage: the group is visible to the queue one cycle after rsp.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_out_pc_p1    <= 64'd0;
      r_out_instr_p1 <= 64'd0;
    end else if (w_load) begin
      r_out_pc_p1    <= r_pc;
      r_out_instr_p1 <= imem_rsp_data;
    end
  end

`ifndef SYNTHESIS
  always @(posedge CLK) begin
    if (RSTn) begin
      assert (!(imem_rsp_valid && (r_state != S_WAIT)))
        else $warning("ifetch_ctrl: imem_rsp_valid outside WAIT ignored");
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: fetch sequencing, redirects, stale-response
// dropping, queue backpressure and asynchronous reset.
module tb_ifetch_ctrl;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        flush;
  logic [63:0] flush_pc;
  logic        branch_pc_valid;
  logic [63:0] branch_pc;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [63:0] imem_rsp_data;
  logic        if_iq_valid;
  logic [63:0] if_iq_pc;
  logic [63:0] if_iq_instr;
  logic        if_iq_ready;

  int checks   = 0;
  int failures = 0;

  ifetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .CLK             (CLK),
    .RSTn            (RSTn),
    .flush           (flush),
    .flush_pc        (flush_pc),
    .branch_pc_valid (branch_pc_valid),
    .branch_pc       (branch_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .if_iq_valid     (if_iq_valid),
    .if_iq_pc        (if_iq_pc),
    .if_iq_instr     (if_iq_instr),
    .if_iq_ready     (if_iq_ready)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // One full REQ -> WAIT -> HOLD -> handshake round, ending back in REQ.
  task automatic do_fetch(input string tag, input logic [63:0] exp_addr,
                          input logic [63:0] exp_pc, input logic [63:0] data);
    chk({tag, "_reqv"}, {63'd0, imem_req_valid}, 64'd1);
    chk({tag, "_addr"}, imem_req_addr, exp_addr);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk({tag, "_wait_reqv"}, {63'd0, imem_req_valid}, 64'd0);
    chk({tag, "_wait_iqv"}, {63'd0, if_iq_valid}, 64'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    step();
    imem_rsp_valid = 1'b0;
    chk({tag, "_iqv"}, {63'd0, if_iq_valid}, 64'd1);
    chk({tag, "_iqpc"}, if_iq_pc, exp_pc);
    chk({tag, "_instr"}, if_iq_instr, data);
    if_iq_ready = 1'b1;
    step();
    if_iq_ready = 1'b0;
  endtask

  initial begin
    RSTn = 1'b0; flush = 1'b0; flush_pc = '0; branch_pc_valid = 1'b0; branch_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; if_iq_ready = 1'b0;
    step(); step();
    chk("rst_iqv", {63'd0, if_iq_valid}, 64'd0);
    chk("rst_iqpc", if_iq_pc, 64'd0);
    chk("rst_instr", if_iq_instr, 64'd0);
    RSTn = 1'b1;
    step();

    // Sequential fetch from the reset PC
    do_fetch("t1a", 64'h8000_0000, 64'h8000_0000, 64'h1111_2222_3333_4444);
    do_fetch("t1b", 64'h8000_0008, 64'h8000_0008, 64'h5555_6666_7777_8888);
    do_fetch("t1c", 64'h8000_0010, 64'h8000_0010, 64'h9999_AAAA_BBBB_CCCC);

    // Branch redirect while holding, with the queue ready in the same cycle
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 64'hDEAD_0000_0000_0018; step(); imem_rsp_valid = 1'b0;
    chk("t2_hold_pc", if_iq_pc, 64'h8000_0018);
    branch_pc_valid = 1'b1; branch_pc = 64'h8000_1006; if_iq_ready = 1'b1;
    step();
    branch_pc_valid = 1'b0; if_iq_ready = 1'b0;
    chk("t2_iqv_drop", {63'd0, if_iq_valid}, 64'd0);
    do_fetch("t2a", 64'h8000_1000, 64'h8000_1006, 64'h0102_0304_0506_0708);
    do_fetch("t2b", 64'h8000_1008, 64'h8000_1008, 64'h1112_1314_1516_1718);

    // Flush and branch together with a response in WAIT: flush wins, rsp dropped
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 64'hBAD0_BAD0_BAD0_BAD0;
    flush = 1'b1; flush_pc = 64'h100; branch_pc_valid = 1'b1; branch_pc = 64'h200;
    step();
    imem_rsp_valid = 1'b0; flush = 1'b0; branch_pc_valid = 1'b0;
    chk("t3_iqv", {63'd0, if_iq_valid}, 64'd0);
    do_fetch("t3", 64'h100, 64'h100, 64'h2122_2324_2526_2728);

    // Redirect in WAIT before the response: the late response is stale
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
    branch_pc_valid = 1'b1; branch_pc = 64'h300;
    step();
    branch_pc_valid = 1'b0;
    chk("t4_wait_reqv", {63'd0, imem_req_valid}, 64'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 64'hBAD1_BAD1_BAD1_BAD1;
    step();
    imem_rsp_valid = 1'b0;
    chk("t4_iqv", {63'd0, if_iq_valid}, 64'd0);
    do_fetch("t4", 64'h300, 64'h300, 64'h3132_3334_3536_3738);

    // Queue backpressure: outputs held for 5 cycles
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 64'h4142_4344_4546_4748; step(); imem_rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t5_iqv", {63'd0, if_iq_valid}, 64'd1);
      chk("t5_iqpc", if_iq_pc, 64'h308);
      chk("t5_instr", if_iq_instr, 64'h4142_4344_4546_4748);
      chk("t5_reqv", {63'd0, imem_req_valid}, 64'd0);
      step();
    end
    if_iq_ready = 1'b1; step(); if_iq_ready = 1'b0;
    chk("t5_next", imem_req_addr, 64'h310);

    // Redirect while the request is not accepted: address follows pc
    flush = 1'b1; flush_pc = 64'h40A; step(); flush = 1'b0;
    chk("t7_reqv", {63'd0, imem_req_valid}, 64'd1);
    do_fetch("t7", 64'h408, 64'h40A, 64'h5152_5354_5556_5758);
    chk("t7_next", imem_req_addr, 64'h410);

    // PC increment wraps at the top of the address space
    flush = 1'b1; flush_pc = 64'hFFFF_FFFF_FFFF_FFFA; step(); flush = 1'b0;
    do_fetch("t8", 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFA, 64'h6162_6364_6566_6768);
    chk("t8_wrap", imem_req_addr, 64'd0);

    // Asynchronous reset mid-WAIT, then a late protocol-violating response
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
    #2 RSTn = 1'b0;
    #1;
    chk("t6_iqv", {63'd0, if_iq_valid}, 64'd0);
    chk("t6_iqpc", if_iq_pc, 64'd0);
    chk("t6_instr", if_iq_instr, 64'd0);
    @(posedge CLK);
    #2 RSTn = 1'b1;
    chk("t6_addr", imem_req_addr, RST_PC);
    imem_rsp_valid = 1'b1; imem_rsp_data = 64'hBAD2_BAD2_BAD2_BAD2;
    step();
    imem_rsp_valid = 1'b0;
    chk("t6_late_iqv", {63'd0, if_iq_valid}, 64'd0);
    chk("t6_late_instr", if_iq_instr, 64'd0);
    do_fetch("t6", RST_PC, RST_PC, 64'h7172_7374_7576_7778);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
